// File: rtl/psum_accumulator_pkg.sv
// Shared constants and FSM encoding for the psum accumulator slice.
package psum_accumulator_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_DRAIN = 2'd1,
        ACC_DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/psum_accumulator_if.sv
// Command, OFIFO drain and readout signals of the psum accumulator.
interface psum_accumulator_if
    import psum_accumulator_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH
) ();

    logic                       acc_start;
    logic                       first_pass;
    logic                       relu_en;
    logic                       ofifo_valid;
    logic [col*psum_bw-1:0]     ofifo_in;
    logic                       ofifo_rd;
    logic                       rd_en;
    logic [$clog2(depth)-1:0]   rd_addr;
    logic [col*psum_bw-1:0]     rd_data;
    logic                       rd_valid;
    logic                       busy;
    logic                       done;

    modport master (
        output acc_start, first_pass, relu_en, ofifo_valid, ofifo_in, rd_en, rd_addr,
        input  ofifo_rd, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  acc_start, first_pass, relu_en, ofifo_valid, ofifo_in, rd_en, rd_addr,
        output ofifo_rd, rd_data, rd_valid, busy, done
    );

endinterface

// File: rtl/psum_sat_add.sv
// One lane: signed add at psum_bw+1 bits, clamped back to psum_bw.
module psum_sat_add #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    output logic [psum_bw-1:0] sum
);

    logic [psum_bw:0] wide;

    // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
    always_comb begin
        wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        sum  = wide[psum_bw-1:0];
        // Top two bits disagree only when the true sum left the psum_bw range.
        if (wide[psum_bw] != wide[psum_bw-1]) begin
            sum = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                : {1'b0, {(psum_bw-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Drains one pass of psum vectors from the OFIFO into a per-row buffer,
// accumulating across passes, with registered ReLU readout.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    psum_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(depth);

    acc_state_e               state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     first_q, relu_q;
    logic                     pop;
    logic [psum_bw-1:0]       buf_q [depth][col];
    logic [psum_bw-1:0]       sum   [col];
    logic [col*psum_bw-1:0]   rd_next;

    always_ff @(posedge clk) begin
        if (reset) state <= ACC_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        bus.ofifo_rd = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        unique case (state)
            ACC_IDLE: begin
                if (bus.acc_start) state_nxt = ACC_DRAIN;
            end
            ACC_DRAIN: begin
                bus.busy     = 1'b1;
                pop          = bus.ofifo_valid;
                bus.ofifo_rd = bus.ofifo_valid;
                if (pop && cnt == CNT_W'(depth - 1)) state_nxt = ACC_DONE;
            end
            ACC_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ACC_IDLE;
            end
            default: state_nxt = ACC_IDLE;
        endcase
    end

    for (genvar l = 0; l < col; l++) begin : g_lane
        psum_sat_add #(.psum_bw(psum_bw)) u_sat_add (
            .a   (buf_q[cnt][l]),
            .b   (bus.ofifo_in[l*psum_bw +: psum_bw]),
            .sum (sum[l])
        );
    end

    always_comb begin
        rd_next = '0;
        for (int l = 0; l < col; l++) begin
            if (!(relu_q && buf_q[bus.rd_addr][l][psum_bw-1]))
                rd_next[l*psum_bw +: psum_bw] = buf_q[bus.rd_addr][l];
        end
    end

    // NOTE: the buffer is a flop array, not a RAM macro, because reset must clear every entry.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            first_q      <= 1'b0;
            relu_q       <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            for (int e = 0; e < depth; e++)
                for (int l = 0; l < col; l++)
                    buf_q[e][l] <= '0;
        end else begin
            bus.rd_valid <= 1'b0;
            if (state == ACC_IDLE) begin
                if (bus.acc_start) begin
                    first_q <= bus.first_pass;
                    relu_q  <= bus.relu_en;
                    cnt     <= '0;
                end
                // Reads use the pre-pass flags and contents even alongside acc_start.
                if (bus.rd_en) begin
                    bus.rd_valid <= 1'b1;
                    bus.rd_data  <= rd_next;
                end
            end
            if (pop) begin
                for (int l = 0; l < col; l++)
                    buf_q[cnt][l] <= first_q ? bus.ofifo_in[l*psum_bw +: psum_bw] : sum[l];
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized self-checking bench for psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    localparam int W    = COL * PSUM_BW;
    localparam int MAXC = 80;

    logic clk;
    logic reset;

    psum_accumulator_if bus ();

    psum_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         model [DEPTH][COL];
    int         vec   [DEPTH][COL];
    bit         relu_m;
    bit         pat   [1:MAXC];
    logic [W-1:0] last_rd;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int s);
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic logic [W-1:0] pack_vec(input int e);
        logic [W-1:0] v;
        int           x;
        v = '0;
        for (int l = 0; l < COL; l++) begin
            x = vec[e][l];
            v[l*PSUM_BW +: PSUM_BW] = x[PSUM_BW-1:0];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] exp_read(input int e);
        logic [W-1:0] v;
        int           x;
        v = '0;
        for (int l = 0; l < COL; l++) begin
            x = (relu_m && model[e][l] < 0) ? 0 : model[e][l];
            v[l*PSUM_BW +: PSUM_BW] = x[PSUM_BW-1:0];
        end
        return v;
    endfunction

    // mode 0: valid held high, 1: toggling, 2: random
    task automatic set_pat(input int mode);
        int n = 0;
        for (int c = 1; c <= MAXC; c++) begin
            pat[c] = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ($urandom_range(0, 2) != 0);
            if (pat[c]) n++;
        end
        if (n < DEPTH) for (int c = 1; c <= MAXC; c++) pat[c] = 1'b1;
    endtask

    task automatic read_check(input string tag, input int a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a[$clog2(DEPTH)-1:0];
        tick();
        bus.rd_en = 1'b0;
        check({tag, "_valid"}, W'(bus.rd_valid), W'(1));
        check({tag, "_data"}, bus.rd_data, exp_read(a));
        last_rd = exp_read(a);
    endtask

    task automatic read_all(input string tag);
        for (int e = 0; e < DEPTH; e++) read_check(tag, e);
    endtask

    task automatic run_pass(input bit first, input bit relu, input int inj);
        int popped   = 0;
        int got_done = 0;
        int exp_done = 0;
        int seen     = 0;
        for (int c = 1; c <= MAXC; c++)
            if (pat[c]) begin
                seen++;
                if (seen == DEPTH) exp_done = c + 1;
            end
        bus.acc_start   = 1'b1;
        bus.first_pass  = first;
        bus.relu_en     = relu;
        bus.ofifo_valid = 1'b0;
        tick();
        bus.acc_start  = 1'b0;
        bus.first_pass = 1'b0;
        bus.relu_en    = 1'b0;
        for (int c = 1; c <= MAXC && got_done == 0; c++) begin
            bus.ofifo_valid = pat[c] && popped < DEPTH;
            bus.ofifo_in    = (popped < DEPTH) ? pack_vec(popped) : '0;
            if (c == inj) begin
                bus.acc_start  = 1'b1;
                bus.first_pass = ~first;
                bus.relu_en    = ~relu;
                bus.rd_en      = 1'b1;
                bus.rd_addr    = '0;
            end
            #1;
            if (c == 1) check("busy_drain", W'(bus.busy), W'(1));
            if (bus.ofifo_rd) popped++;
            tick();
            bus.acc_start  = 1'b0;
            bus.first_pass = 1'b0;
            bus.relu_en    = 1'b0;
            bus.rd_en      = 1'b0;
            if (c == inj) begin
                check("inj_rd_valid", W'(bus.rd_valid), W'(0));
                check("inj_rd_hold", bus.rd_data, last_rd);
            end
            if (bus.done) got_done = c + 1;
        end
        bus.ofifo_valid = 1'b0;
        check("pops", W'(popped), W'(DEPTH));
        check("done_cycle", W'(got_done), W'(exp_done));
        bus.ofifo_valid = 1'b1;
        #1;
        check("done_no_pop", W'(bus.ofifo_rd), W'(0));
        bus.ofifo_valid = 1'b0;
        tick();
        check("done_pulse", W'(bus.done), W'(0));
        check("idle_busy", W'(bus.busy), W'(0));
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++)
                model[e][l] = first ? vec[e][l] : clamp(model[e][l] + vec[e][l]);
        relu_m = relu;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++)
                model[e][l] = 0;
        relu_m  = 1'b0;
        last_rd = '0;
    endtask

    task automatic fill_random(input int mag);
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++)
                vec[e][l] = int'($urandom_range(0, 2 * mag)) - mag;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.acc_start   = 1'b0;
        bus.first_pass  = 1'b0;
        bus.relu_en     = 1'b0;
        bus.ofifo_valid = 1'b1;
        bus.ofifo_in    = '0;
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        apply_reset();

        check("rst_ofifo_rd", W'(bus.ofifo_rd), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_rd_valid", W'(bus.rd_valid), W'(0));
        check("rst_rd_data", bus.rd_data, '0);
        bus.ofifo_valid = 1'b0;
        read_check("rst_read", 3);

        // Lane i = i+1, overwrite then accumulate, then subtract 3.
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++) vec[e][l] = l + 1;
        set_pat(0);
        run_pass(1'b1, 1'b0, 0);
        read_check("p1_addr5", 5);
        run_pass(1'b0, 1'b0, 0);
        read_check("p2_addr5", 5);
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++) vec[e][l] = -3;
        run_pass(1'b0, 1'b0, 0);
        read_check("p3_addr5", 5);

        // Saturation at both rails.
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++) vec[e][l] = l[0] ? -32763 : 32752;
        run_pass(1'b1, 1'b0, 0);
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++) vec[e][l] = l[0] ? -16 : 32;
        run_pass(1'b0, 1'b0, 0);
        read_all("sat");

        // ReLU on and off over the same -7/+7 data.
        for (int e = 0; e < DEPTH; e++)
            for (int l = 0; l < COL; l++) vec[e][l] = l[0] ? 7 : -7;
        run_pass(1'b1, 1'b1, 0);
        read_check("relu_on", 2);
        run_pass(1'b1, 1'b0, 0);
        read_check("relu_off", 2);

        // Toggling valid with an ignored acc_start/rd_en mid-pass.
        fill_random(2000);
        set_pat(1);
        run_pass(1'b0, 1'b0, 5);
        read_all("toggle");

        // Randomized passes with random valid gaps and flags.
        for (int p = 0; p < 6; p++) begin
            fill_random((p % 2 == 0) ? 32768 : 500);
            set_pat(2);
            run_pass(p == 0 || $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                     (p == 3) ? 7 : 0);
            read_check("rand", int'($urandom_range(0, DEPTH - 1)));
        end
        read_all("rand_all");

        // Reset after 7 pops aborts the pass and clears the buffer.
        fill_random(1000);
        bus.acc_start  = 1'b1;
        bus.first_pass = 1'b1;
        tick();
        bus.acc_start  = 1'b0;
        bus.first_pass = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.ofifo_valid = 1'b1;
            bus.ofifo_in    = pack_vec(c);
            tick();
        end
        reset = 1'b1;
        tick();
        #1;
        check("abort_ofifo_rd", W'(bus.ofifo_rd), W'(0));
        check("abort_busy", W'(bus.busy), W'(0));
        bus.ofifo_valid = 1'b0;
        apply_reset();
        read_all("abort_clear");
        fill_random(1000);
        set_pat(0);
        run_pass(1'b1, 1'b0, 0);
        read_all("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
